// File: rtl/h_alpha_ingest_pkg.sv
// Shared defaults and FSM state encoding for the H-row / alpha-column frame ingest block.
package h_alpha_pkg;

    localparam int J_DEFAULT    = 14;
    localparam int I_DEFAULT    = 7;
    localparam int A_DEFAULT    = 2;
    localparam int ALPHA_BYTE_W = 8;

    typedef enum logic [2:0] {
        S_H      = 3'd0,
        S_A      = 3'd1,
        S_FULL   = 3'd2,
        S_HDRAIN = 3'd3,
        S_ADRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/h_alpha_ingest_stream_frame_counter.sv
// Beat counter for one framed stream: tracks position in the frame, flags tlast
// arriving early or missing at the last slot, and signals when to drain.
module stream_frame_counter #(
    parameter  int N  = 7,
    localparam int CW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          beat_i,
    input  logic          last_i,
    output logic [CW-1:0] cnt_o,
    output logic          done_o,
    output logic          len_err_o,
    output logic          drain_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_end;

    assign at_end    = (cnt_q == CW'(N - 1));
    assign done_o    = beat_i & last_i & at_end;
    // Early tlast and a missing tlast on the final slot are both length errors.
    assign len_err_o = beat_i & (last_i ^ at_end);
    assign drain_o   = beat_i & ~last_i & at_end;
    assign cnt_o     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (beat_i) begin
            cnt_d = (last_i || at_end) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/h_alpha_ingest.sv
// Frame ingest endpoint: captures I H rows then A alpha columns, holds them for the
// decoder core behind a registered read port. Optional counters: H_ALPHA_INGEST_FRAME_CNT_EN.
module h_alpha_ingest
    import h_alpha_pkg::*;
#(
    parameter  int J       = J_DEFAULT,
    parameter  int I       = I_DEFAULT,
    parameter  int A       = A_DEFAULT,
    localparam int I_WIDTH = $clog2(I) + 1,
    localparam int A_WIDTH = $clog2(A) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [J-1:0]              H_row,
    input  logic                      H_row_tvalid,
    input  logic                      H_row_tlast,
    input  logic [J*ALPHA_BYTE_W-1:0] alpha_u_col,
    input  logic                      alpha_u_col_tvalid,
    input  logic                      alpha_u_col_tlast,
    output logic                      frame_valid,
    input  logic                      frame_release,
    input  logic [I_WIDTH-1:0]        rd_addr,
    output logic [J-1:0]              rd_h_data,
    output logic [J*ALPHA_BYTE_W-1:0] rd_alpha_data,
    output logic                      h_len_err,
    output logic                      alpha_len_err,
    output logic                      ovf_err,
`ifdef H_ALPHA_INGEST_FRAME_CNT_EN
    output logic [15:0]               frame_cnt,
    output logic [7:0]                err_cnt,
`endif
    input  logic                      err_clr
);

    state_t state_q, state_d;

    logic [J-1:0]              h_mem_q [I];
    logic [J*ALPHA_BYTE_W-1:0] a_mem_q [A];

    logic               h_beat, a_beat;
    logic [I_WIDTH-1:0] h_cnt;
    logic [A_WIDTH-1:0] a_cnt;
    logic               h_done, h_len_evt, h_drain;
    logic               a_done, a_len_evt, a_drain;
    logic               h_err_set, a_err_set, ovf_set;
    logic               h_len_err_q, alpha_len_err_q, ovf_err_q;

    assign h_beat = H_row_tvalid && (state_q == S_H);
    assign a_beat = alpha_u_col_tvalid && (state_q == S_A);

    stream_frame_counter #(.N(I)) u_h_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_i    (h_beat),
        .last_i    (H_row_tlast),
        .cnt_o     (h_cnt),
        .done_o    (h_done),
        .len_err_o (h_len_evt),
        .drain_o   (h_drain)
    );

    stream_frame_counter #(.N(A)) u_a_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_i    (a_beat),
        .last_i    (alpha_u_col_tlast),
        .cnt_o     (a_cnt),
        .done_o    (a_done),
        .len_err_o (a_len_evt),
        .drain_o   (a_drain)
    );

    always_comb begin
        state_d   = state_q;
        h_err_set = 1'b0;
        a_err_set = 1'b0;
        ovf_set   = 1'b0;
        case (state_q)
            S_H: begin
                h_err_set = h_len_evt;
                a_err_set = alpha_u_col_tvalid;
                if (h_done)       state_d = S_A;
                else if (h_drain) state_d = S_HDRAIN;
            end
            S_HDRAIN: begin
                a_err_set = alpha_u_col_tvalid;
                if (H_row_tvalid && H_row_tlast) state_d = S_H;
            end
            S_A: begin
                a_err_set = a_len_evt;
                h_err_set = H_row_tvalid;
                // Any alpha framing error abandons the H rows captured for this frame.
                if (a_done)         state_d = S_FULL;
                else if (a_drain)   state_d = S_ADRAIN;
                else if (a_len_evt) state_d = S_H;
            end
            S_ADRAIN: begin
                h_err_set = H_row_tvalid;
                if (alpha_u_col_tvalid && alpha_u_col_tlast) state_d = S_H;
            end
            S_FULL: begin
                ovf_set = H_row_tvalid | alpha_u_col_tvalid;
                if (frame_release) state_d = S_H;
            end
            default: state_d = S_H;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_H;
            h_len_err_q     <= 1'b0;
            alpha_len_err_q <= 1'b0;
            ovf_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            // A new error in the same cycle as err_clr takes priority.
            h_len_err_q     <= (h_len_err_q & ~err_clr) | h_err_set;
            alpha_len_err_q <= (alpha_len_err_q & ~err_clr) | a_err_set;
            ovf_err_q       <= (ovf_err_q & ~err_clr) | ovf_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < I; r++) h_mem_q[r] <= '0;
            for (int c = 0; c < A; c++) a_mem_q[c] <= '0;
        end else begin
            if (h_beat) h_mem_q[h_cnt] <= H_row;
            if (a_beat) a_mem_q[a_cnt] <= alpha_u_col;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_h_data     <= '0;
            rd_alpha_data <= '0;
        end else begin
            rd_h_data     <= (rd_addr < I_WIDTH'(I)) ? h_mem_q[rd_addr] : '0;
            rd_alpha_data <= (rd_addr < I_WIDTH'(A)) ? a_mem_q[rd_addr[A_WIDTH-1:0]] : '0;
        end
    end

    assign frame_valid   = (state_q == S_FULL);
    assign h_len_err     = h_len_err_q;
    assign alpha_len_err = alpha_len_err_q;
    assign ovf_err       = ovf_err_q;

`ifdef H_ALPHA_INGEST_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (a_done) frame_cnt_q <= frame_cnt_q + 16'd1;
            if ((h_err_set || a_err_set || ovf_set) && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: doc/h_alpha_ingest.md
Name: h_alpha_ingest

Overview:
- Receive-side endpoint for the parity-check row stream (H_row) and the soft-value column stream (alpha_u_col) driven by the stimulus/upstream sender.
- Captures one frame (I rows of H, then A alpha columns) into register storage and checks tlast framing on both streams.
- Presents the frame to the downstream decoder core through a registered random-access read port, and holds it until the core releases it.

Parameters:
- J, 14, H row width / number of alpha bytes per column
- I, 7, H rows per frame
- A, 2, alpha columns per frame
- J_WIDTH, $clog2(J)+1, localparam
- I_WIDTH, $clog2(I)+1, localparam; row counter/address width
- A_WIDTH, $clog2(A)+1, localparam; column counter/address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- H_row  in  J  H row beat
- H_row_tvalid  in  1  H beat valid (no backpressure)
- H_row_tlast  in  1  last H row of frame
- alpha_u_col  in  J*8  alpha column; byte k at [8k+7:8k]
- alpha_u_col_tvalid  in  1  alpha beat valid
- alpha_u_col_tlast  in  1  last alpha column
- frame_valid  out  1  complete frame held
- frame_release  in  1  core done; free storage
- rd_addr  in  I_WIDTH  row index / column index
- rd_h_data  out  J  registered H row[rd_addr]
- rd_alpha_data  out  J*8  registered alpha col[rd_addr]
- h_len_err  out  1  sticky H framing error
- alpha_len_err  out  1  sticky alpha framing error
- ovf_err  out  1  sticky beat-while-full error
- err_clr  in  1  clears all sticky errors

Behaviour:
- Reset: all outputs 0, all storage 0, counters 0, state S_H.
- Interface: one clock, clk; reset asynchronous, active-low, rst_n.
- No tready. Every beat with tvalid=1 is consumed in its cycle. tlast is ignored when tvalid=0.
- S_H:
  - An H beat writes row[h_cnt] and increments h_cnt.
  - tlast with h_cnt==I-1: go to S_A, h_cnt<=0.
  - tlast with h_cnt<I-1: set h_len_err, h_cnt<=0, stay in S_H (partial frame discarded).
  - Beat at h_cnt==I-1 without tlast: set h_len_err, go to S_HDRAIN.
  - An alpha beat in S_H: set alpha_len_err, beat dropped.
- S_HDRAIN: drops H beats until one carries tlast, then goes to S_H with h_cnt=0.
- S_A: same rules as S_H, using a_cnt, A, alpha_len_err and S_ADRAIN.
  - A correct alpha tlast goes to S_FULL. frame_valid rises the cycle after the tlast beat.
  - An alpha framing error returns to S_H. The H rows already stored are invalidated.
  - An H beat in S_A sets h_len_err and is dropped.
- S_ADRAIN: drops alpha beats until one carries tlast, then goes to S_H.
- S_FULL:
  - frame_valid=1 and storage is frozen.
  - Any beat on either stream sets ovf_err and is dropped.
  - frame_release: go to S_H next cycle, frame_valid<=0.
  - A beat in the same cycle as frame_release is dropped and flagged.
  - frame_release outside S_FULL is ignored.
- Read port:
  - One-cycle latency: rd_*_data at cycle N+1 reflects rd_addr at cycle N. Readable in any state.
  - rd_h_data returns 0 for rd_addr>=I; rd_alpha_data returns 0 for rd_addr>=A.
- Sticky errors:
  - err_clr clears all three.
  - If err_clr and a new error occur in the same cycle, the error wins (stays 1).
- Reset mid-frame: returns to S_H, counters 0, frame discarded.

Optional Feature:
- Macro: H_ALPHA_INGEST_FRAME_CNT_EN
- Defined:
  - Adds output frame_cnt[15:0], reset 0.
  - Increments on every S_A->S_FULL transition and wraps from 0xFFFF to 0.
  - Adds output err_cnt[7:0], which increments on each error-setting event and saturates at 0xFF. err_clr does not clear either counter.
- Undefined: neither port nor the counters exist. All other behaviour is identical.

Decomposition:
- Shared package h_alpha_pkg:
  - State encoding: S_H, S_A, S_FULL, S_HDRAIN, S_ADRAIN as 3-bit localparams.
  - Default J/I/A.
  - ALPHA_BYTE_W=8.
- Natural sub-module: stream_frame_counter.
  - One instance per stream; counter, tlast check, len-error and drain detection.
  - Parameterised by beat count (I or A).

Test Plan:
- Nominal:
  - Stimulus: H rows 0x18A3, then 0x0D4A, 0x14C5, 0x230B, 0x22B4, 0x2538, then 0x1A54 with tlast; then alpha col0 (LSB byte 0xFF, MSB byte 0x74) and col1 (LSB 0x01, MSB 0x8B) with tlast.
  - Response: frame_valid=1 one cycle after col1. rd_addr=6 gives rd_h_data=0x1A54 next cycle. rd_addr=1 gives rd_alpha_data[7:0]=0x01. No errors.
- Short H:
  - Stimulus: tlast on the 5th row.
  - Response: h_len_err=1, h_cnt reset. A following correct 7-row frame plus 2 alpha columns gives frame_valid=1.
- Long alpha:
  - Stimulus: 3 alpha columns, tlast on the 3rd.
  - Response: alpha_len_err=1 after col1; col2 is drained; state returns to S_H; frame_valid stays 0.
- Overflow:
  - Stimulus: H beat while frame_valid=1, with and without simultaneous frame_release.
  - Response: ovf_err=1 in both cases, storage unchanged; frame_valid=0 the cycle after release.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after 3 H rows.
  - Response: all outputs 0 immediately; rd_h_data=0 for every address after reset.
- With H_ALPHA_INGEST_FRAME_CNT_EN defined:
  - Stimulus: two good frames, each released.
  - Response: frame_cnt=2.
  - Stimulus: one short-H error.
  - Response: err_cnt=1.
